// File: rtl/seg7_if.sv
// Sample/result bundle for the seven-segment decoder monitor.
// master drives samples and observes results; slave is the monitor itself.
interface seg7_if;
  logic        sample_en;
  logic [7:0]  seg0;
  logic [7:0]  seg1;
  logic [7:0]  seg2;
  logic [9:0]  value;
  logic [11:0] digits;
  logic        value_valid;
  logic        code_err;
  logic        seq_err;
  logic        locked;
  logic [7:0]  err_cnt;

  modport master (
    output sample_en, seg0, seg1, seg2,
    input  value, digits, value_valid, code_err, seq_err, locked, err_cnt
  );

  modport slave (
    input  sample_en, seg0, seg1, seg2,
    output value, digits, value_valid, code_err, seq_err, locked, err_cnt
  );
endinterface

// File: rtl/seg7_decoder_monitor.sv
// Decodes a sampled 3-digit seven-segment display and checks it counts up by one.
// Define SEG7_DP_CHECK_EN to treat any lit decimal point as an illegal pattern.
module seg7_decoder_monitor (
  input  logic  clk,
  input  logic  rst,
  seg7_if.slave bus
);

  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

  // Returns {legal, digit}; only segments a..g take part in the match.
  function automatic logic [4:0] seg_decode(input logic [7:0] pat);
    logic [4:0] r;
    case (pat[7:1])
      7'h7E:   r = 5'h10;
      7'h30:   r = 5'h11;
      7'h6D:   r = 5'h12;
      7'h79:   r = 5'h13;
      7'h33:   r = 5'h14;
      7'h5B:   r = 5'h15;
      7'h5F:   r = 5'h16;
      7'h70:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h73:   r = 5'h19;
      default: r = 5'h00;
    endcase
`ifdef SEG7_DP_CHECK_EN
    if (pat[0]) r = 5'h00;
`endif
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  state_t      state_q, state_n;
  logic [9:0]  prev_q, prev_n;
  logic [9:0]  value_p1;
  logic [11:0] digits_p1;
  logic        vld_p1, cerr_p1, serr_p1;
  logic [7:0]  err_cnt_p1;

  logic [4:0]  dec0, dec1, dec2;
  logic        legal;
  logic [9:0]  samp_val, prev_inc;
  logic        vld_n, cerr_n, serr_n, err_inc, upd;

  assign dec0     = seg_decode(bus.seg0);
  assign dec1     = seg_decode(bus.seg1);
  assign dec2     = seg_decode(bus.seg2);
  assign legal    = dec0[4] & dec1[4] & dec2[4];
  assign samp_val = {6'd0, dec2[3:0]} * 10'd100 + {6'd0, dec1[3:0]} * 10'd10
                  + {6'd0, dec0[3:0]};
  assign prev_inc = (prev_q == 10'd999) ? 10'd0 : prev_q + 10'd1;

  always_comb begin
    state_n = state_q;
    prev_n  = prev_q;
    vld_n   = 1'b0;
    cerr_n  = 1'b0;
    serr_n  = 1'b0;
    err_inc = 1'b0;
    upd     = 1'b0;
    if (bus.sample_en) begin
      if (!legal) begin
        // An illegal code masks any sequence check on the same sample.
        cerr_n  = 1'b1;
        err_inc = 1'b1;
        state_n = UNLOCKED;
      end else begin
        vld_n = 1'b1;
        upd   = 1'b1;
        case (state_q)
          UNLOCKED: begin
            prev_n  = samp_val;
            state_n = CHECK;
          end
          CHECK: begin
            prev_n = samp_val;
            if (samp_val == prev_inc) state_n = LOCKED;
          end
          LOCKED: begin
            if (samp_val == prev_inc) begin
              prev_n = samp_val;
            end else if (samp_val != prev_q) begin
              serr_n  = 1'b1;
              err_inc = 1'b1;
              prev_n  = samp_val;
              state_n = CHECK;
            end
          end
          default: state_n = UNLOCKED;
        endcase
      end
    end
  end

  // Stage p1: registered outputs, one cycle after the sampling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UNLOCKED;
      prev_q     <= 10'd0;
      value_p1   <= 10'd0;
      digits_p1  <= 12'd0;
      vld_p1     <= 1'b0;
      cerr_p1    <= 1'b0;
      serr_p1    <= 1'b0;
      err_cnt_p1 <= 8'd0;
    end else begin
      state_q <= state_n;
      prev_q  <= prev_n;
      vld_p1  <= vld_n;
      cerr_p1 <= cerr_n;
      serr_p1 <= serr_n;
      if (upd) begin
        value_p1  <= samp_val;
        digits_p1 <= {dec2[3:0], dec1[3:0], dec0[3:0]};
      end
      if (err_inc) err_cnt_p1 <= sat_inc(err_cnt_p1);
    end
  end

  assign bus.value       = value_p1;
  assign bus.digits      = digits_p1;
  assign bus.value_valid = vld_p1;
  assign bus.code_err    = cerr_p1;
  assign bus.seq_err     = serr_p1;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.err_cnt     = err_cnt_p1;

endmodule

// File: tb/tb_seg7_decoder_monitor.sv
// Directed table-driven bench for seg7_decoder_monitor plus saturation/reset sequences.
module tb_seg7_decoder_monitor;

`ifdef SEG7_DP_CHECK_EN
  localparam int DP = 1;
`else
  localparam int DP = 0;
`endif

  typedef struct {
    logic [7:0] s2, s1, s0;
    int val, vld, cerr, serr, lck, err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t vecs[16];

  seg7_if bus ();
  seg7_decoder_monitor dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int d);
    case (d)
      0: return 8'hFC; 1: return 8'h60; 2: return 8'hDA; 3: return 8'hF2;
      4: return 8'h66; 5: return 8'hB6; 6: return 8'hBE; 7: return 8'hE0;
      8: return 8'hFE; 9: return 8'hE6;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int bcd(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [7:0] s2, input logic [7:0] s1,
                      input logic [7:0] s0, input int val, input int vld,
                      input int cerr, input int serr, input int lck, input int err);
    vecs[i].s2 = s2; vecs[i].s1 = s1; vecs[i].s0 = s0;
    vecs[i].val = val; vecs[i].vld = vld; vecs[i].cerr = cerr;
    vecs[i].serr = serr; vecs[i].lck = lck; vecs[i].err = err;
  endtask

  task automatic setn(input int i, input int n, input int val, input int vld,
                      input int cerr, input int serr, input int lck, input int err);
    setv(i, pat(n / 100), pat((n / 10) % 10), pat(n % 10), val, vld, cerr, serr, lck, err);
  endtask

  task automatic apply(input logic [7:0] s2, input logic [7:0] s1, input logic [7:0] s0);
    @(negedge clk);
    bus.seg2 = s2; bus.seg1 = s1; bus.seg0 = s0;
    bus.sample_en = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int val, input int vld, input int cerr,
                         input int serr, input int lck, input int err);
    chk({tag, ".value"},       int'(bus.value), val);
    chk({tag, ".digits"},      int'(bus.digits), bcd(val));
    chk({tag, ".value_valid"}, int'(bus.value_valid), vld);
    chk({tag, ".code_err"},    int'(bus.code_err), cerr);
    chk({tag, ".seq_err"},     int'(bus.seq_err), serr);
    chk({tag, ".locked"},      int'(bus.locked), lck);
    chk({tag, ".err_cnt"},     int'(bus.err_cnt), err);
  endtask

  initial begin
    // seg2 hundreds, seg1 tens, seg0 ones
    setn(0, 0,   0,   1, 0, 0, 0, 0);
    setn(1, 998, 998, 1, 0, 0, 0, 0);
    setn(2, 999, 999, 1, 0, 0, 1, 0);
    setn(3, 0,   0,   1, 0, 0, 1, 0);
    setn(4, 0,   0,   1, 0, 0, 1, 0);
    setv(5, 8'hFC, 8'hFC, 8'h00, 0, 0, 1, 0, 0, 1);
    setn(6, 3,   3,   1, 0, 0, 0, 1);
    setn(7, 4,   4,   1, 0, 0, 1, 1);
    setn(8, 5,   5,   1, 0, 0, 1, 1);
    setn(9, 7,   7,   1, 0, 1, 0, 2);
    setn(10, 8,  8,   1, 0, 0, 1, 2);
    setv(11, 8'hFC, 8'h00, 8'hFC, 8, 0, 1, 0, 0, 3);
`ifdef SEG7_DP_CHECK_EN
    setv(12, 8'hFC, 8'hFC, 8'hFD, 8, 0, 1, 0, 0, 4);
    setv(15, 8'hE1, 8'hE6, 8'hFE, 124, 0, 1, 0, 0, 5);
`else
    setv(12, 8'hFC, 8'hFC, 8'hFD, 0, 1, 0, 0, 0, 3);
    setv(15, 8'hE1, 8'hE6, 8'hFE, 798, 1, 0, 1, 0, 4);
`endif
    setn(13, 123, 123, 1, 0, 0, 0, 3 + DP);
    setn(14, 124, 124, 1, 0, 0, 1, 3 + DP);

    rst = 1'b1;
    bus.sample_en = 1'b0;
    bus.seg0 = 8'h00; bus.seg1 = 8'h00; bus.seg2 = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].s2, vecs[i].s1, vecs[i].s0);
      chk_all($sformatf("vec%0d", i), vecs[i].val, vecs[i].vld, vecs[i].cerr,
              vecs[i].serr, vecs[i].lck, vecs[i].err);
      @(negedge clk);
      chk_all($sformatf("idle%0d", i), vecs[i].val, 0, 0, 0, vecs[i].lck, vecs[i].err);
    end

    // Saturate the error counter with a burst of illegal samples
    for (int i = 0; i < 300; i++) apply(8'hFC, 8'hFC, 8'h00);
    chk_all("sat", 124 + 674 * (1 - DP), 0, 1, 0, 0, 255);

    apply(pat(0), pat(1), pat(0));
    apply(pat(0), pat(1), pat(1));
    chk_all("relock", 11, 1, 0, 0, 1, 255);

    // Reset coincident with a sample while locked: sample discarded
    @(negedge clk);
    bus.seg2 = pat(0); bus.seg1 = pat(1); bus.seg0 = pat(3);
    bus.sample_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0;
    rst = 1'b0;
    chk_all("rst_mid", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_all("rst_after", 0, 0, 0, 0, 0, 0);

    // After reset, tracking restarts from UNLOCKED
    apply(pat(0), pat(1), pat(2));
    chk_all("restart", 12, 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_decoder_monitor.md
SEG7_DECODER_MONITOR -- requirements
Module: seg7_decoder_monitor

Interface
REQ-001 The block SHALL use a single clock domain: clk; reset rst is synchronous and active-high.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- sample_en  in  1  capture seg0..seg2 on this edge.
- seg0  in  8  ones-digit segment pattern, bit7=a .. bit1=g, bit0=dp.
- seg1  in  8  tens-digit segment pattern, same bit order.
- seg2  in  8  hundreds-digit segment pattern, same bit order.
- value  out  10  decoded binary value, 0..999.
- digits  out  12  decoded BCD {d2,d1,d0}.
- value_valid  out  1  one-cycle pulse, value/digits updated.
- code_err  out  1  one-cycle pulse, illegal pattern sampled.
- seq_err  out  1  one-cycle pulse, count-sequence violation.
- locked  out  1  level, tracking a valid incrementing sequence.
- err_cnt  out  8  saturating error counter.

Function
REQ-003 Decode table SHALL be: FC=0, 60=1, DA=2, F2=3, 66=4, B6=5, BE=6, E0=7, FE=8, E6=9; any other pattern is illegal.
REQ-004 value SHALL equal d2*100 + d1*10 + d0, computed to 10 bits with no truncation.
REQ-005 All outputs SHALL be registered; the response to a sample SHALL appear exactly one cycle after the sampling edge.
REQ-006 With sample_en=0 the block SHALL hold all state, drive value_valid, code_err and seq_err to 0, and hold value, digits, locked and err_cnt.
REQ-007 If any digit of a sample is illegal, the block SHALL:
- pulse code_err and increment err_cnt by 1;
- hold value and digits, keep value_valid=0;
- go to UNLOCKED.
REQ-008 On a legal sample, the block SHALL update value and digits and pulse value_valid.
REQ-009 The FSM SHALL have three states: UNLOCKED, CHECK, LOCKED; locked=1 only in LOCKED.
REQ-010 UNLOCKED: on a legal sample, the block SHALL store it as prev and go to CHECK.
REQ-011 CHECK: on a legal sample equal to (prev+1) mod 1000, the block SHALL go to LOCKED; otherwise it SHALL stay in CHECK; prev SHALL be updated in both cases; seq_err SHALL never assert in CHECK.
REQ-012 LOCKED, legal sample:
- equal to prev: no error, stay LOCKED (held display);
- equal to (prev+1) mod 1000: update prev, stay LOCKED;
- otherwise: pulse seq_err, increment err_cnt, set prev to the sample, go to CHECK.
REQ-013 Wrap-around: with prev=999, a sample of 0 SHALL count as a valid increment.
REQ-014 If a sample is both illegal and out of sequence, the block SHALL assert only code_err, and err_cnt SHALL increment by exactly 1.
REQ-015 err_cnt SHALL saturate at 255 and never wrap.

Reset
REQ-016 While rst=1 on a clock edge, the block SHALL set: state=UNLOCKED, prev=0, value=0, digits=0, value_valid=0, code_err=0, seq_err=0, locked=0, err_cnt=0.
REQ-017 rst SHALL take priority over a simultaneous sample_en, and the sample SHALL be discarded.
REQ-018 rst asserted mid-operation (any state) SHALL abort tracking, with no error pulse on the following cycle.

Configuration
REQ-019 When macro SEG7_DP_CHECK_EN is defined, a sample with bit0 (dp)=1 on any digit SHALL be treated as illegal per REQ-007.
REQ-020 When SEG7_DP_CHECK_EN is undefined, bit0 SHALL be ignored, and decode SHALL use bits 7..1 only (e.g. FD decodes as 0).

Verification
REQ-021 rst, then sample FC/FC/FC -> next cycle: value=0, digits=000, value_valid=1, locked=0, err_cnt=0.
REQ-022 Samples 998, 999, 000 on consecutive enabled cycles -> locked=1 after the 999 response, no seq_err at the wrap, value=0.
REQ-023 While locked, sample seg0=00 -> code_err=1 for one cycle, err_cnt=1, locked=0, value unchanged.
REQ-024 Locked at 005, then sample 007 -> seq_err=1, err_cnt+1, locked=0, value=7; next sample 008 -> locked=1.
REQ-025 Sample seg0=FD, seg1=seg2=FC -> with SEG7_DP_CHECK_EN: code_err=1; without it: value=0, value_valid=1.
REQ-026 Force 300 errors, then assert rst mid-LOCKED -> err_cnt holds 255 before reset; after the reset edge all outputs are 0.
